// File: rtl/popcnt_batch_stats.sv
// popcnt_batch_stats
//   Watches the ready/count outputs of the ones-counter datapath and captures one
//   population count per rising edge of rdy. It collects BATCH valid counts and
//   then presents their sum, maximum and minimum on a registered valid/ack port.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_b      asynchronous active-low reset
//   rdy        upstream ready flag; a rising edge marks a new count
//   cnt        upstream ones count, stable while rdy is high
//   clear      synchronous batch abort: drops the partial batch and sticky flags
//   out_ack    consumer accepts the held result
//   out_valid  a batch result is held on sum_out/max_out/min_out
//   sum_out    sum of the BATCH counts of the last completed batch
//   max_out    largest count of the last completed batch
//   min_out    smallest count of the last completed batch
//   overrun    sticky: a completed batch replaced a result nobody had acked
//   range_err  sticky: a count above DATA_SIZE was seen and discarded
module popcnt_batch_stats #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_W     = 4,
  parameter int BATCH     = 4,
  localparam int SUM_W    = $clog2(BATCH * DATA_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             rdy,
  input  logic [CNT_W-1:0] cnt,
  input  logic             clear,
  input  logic             out_ack,
  output logic             out_valid,
  output logic [SUM_W-1:0] sum_out,
  output logic [CNT_W-1:0] max_out,
  output logic [CNT_W-1:0] min_out,
  output logic             overrun,
  output logic             range_err
);

  localparam int IDX_W = $clog2(BATCH);
  localparam logic [CNT_W-1:0] DATA_MAX = CNT_W'(DATA_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH - 1);

  logic             rdy_q;
  logic [SUM_W-1:0] sum_acc;
  logic [CNT_W-1:0] max_acc;
  logic [CNT_W-1:0] min_acc;
  logic [IDX_W-1:0] idx;

  logic             take;
  logic             in_range;
  logic             accept;
  logic             complete;
  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] max_nxt;
  logic [CNT_W-1:0] min_nxt;

  // Decode the sample event and precompute the accumulator values that would
  // result from taking this cycle's count. A clear in the same cycle wins over
  // the sample, and out-of-range counts never reach the accumulators.
  always_comb begin
    take     = rdy & ~rdy_q & ~clear;
    in_range = (cnt <= DATA_MAX);
    accept   = take & in_range;
    complete = accept & (idx == LAST_IDX);
    sum_nxt  = sum_acc + SUM_W'(cnt);
    max_nxt  = (cnt > max_acc) ? cnt : max_acc;
    min_nxt  = (cnt < min_acc) ? cnt : min_acc;
  end

  // The delayed copy of rdy resets high so that a rdy already asserted when
  // reset is released is not mistaken for a fresh rising edge. It keeps
  // tracking rdy even while clear is asserted.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy;
    end
  end

  // Running accumulators for the batch in progress. They restart on clear and
  // after the final sample of a batch, since that sample goes straight to the
  // output registers. min starts at DATA_SIZE so the first sample always wins.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sum_acc <= '0;
      max_acc <= '0;
      min_acc <= DATA_MAX;
      idx     <= '0;
    end else if (clear || complete) begin
      sum_acc <= '0;
      max_acc <= '0;
      min_acc <= DATA_MAX;
      idx     <= '0;
    end else if (accept) begin
      sum_acc <= sum_nxt;
      max_acc <= max_nxt;
      min_acc <= min_nxt;
      idx     <= idx + IDX_W'(1);
    end
  end

  // Output holding registers. A completing batch always loads and raises
  // out_valid, even if an earlier result is still pending; otherwise an ack
  // drops out_valid but leaves the data in place for anyone still looking.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      sum_out   <= '0;
      max_out   <= '0;
      min_out   <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      sum_out   <= sum_nxt;
      max_out   <= max_nxt;
      min_out   <= min_nxt;
    end else if (out_ack) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by clear or reset. An overrun is a batch
  // landing on an unacked result; an ack in the same cycle counts as taken.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      overrun   <= 1'b0;
      range_err <= 1'b0;
    end else if (clear) begin
      overrun   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (complete && out_valid && !out_ack) begin
        overrun <= 1'b1;
      end
      if (take && !in_range) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_popcnt_batch_stats.sv
// tb_popcnt_batch_stats
//   Drives popcnt_batch_stats with directed scenarios followed by a random run,
//   comparing every output after every clock against a behavioural model that
//   keeps the current batch as a queue of accepted counts.
module tb_popcnt_batch_stats;

  localparam int DATA_SIZE = 8;
  localparam int CNT_W     = 4;
  localparam int BATCH     = 4;
  localparam int SUM_W     = $clog2(BATCH * DATA_SIZE + 1);

  logic             clk;
  logic             rst_b;
  logic             rdy;
  logic [CNT_W-1:0] cnt;
  logic             clear;
  logic             out_ack;
  logic             out_valid;
  logic [SUM_W-1:0] sum_out;
  logic [CNT_W-1:0] max_out;
  logic [CNT_W-1:0] min_out;
  logic             overrun;
  logic             range_err;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model state
  int q[$];
  bit m_rdy_prev;
  bit m_valid;
  int m_sum;
  int m_max;
  int m_min;
  bit m_overrun;
  bit m_range;

  popcnt_batch_stats #(
    .DATA_SIZE(DATA_SIZE),
    .CNT_W(CNT_W),
    .BATCH(BATCH)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .rdy(rdy),
    .cnt(cnt),
    .clear(clear),
    .out_ack(out_ack),
    .out_valid(out_valid),
    .sum_out(sum_out),
    .max_out(max_out),
    .min_out(min_out),
    .overrun(overrun),
    .range_err(range_err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch reports tag/observed/expected.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Model after reset: empty batch, everything zero, rdy history treated as high.
  task automatic model_reset();
    q.delete();
    m_rdy_prev = 1'b1;
    m_valid    = 1'b0;
    m_sum      = 0;
    m_max      = 0;
    m_min      = 0;
    m_overrun  = 1'b0;
    m_range    = 1'b0;
  endtask

  // Model of one clock edge, expressed from the batch rules: a rising edge of
  // rdy offers a count; legal counts join the batch; a full batch publishes
  // its sum/max/min computed over the whole list.
  task automatic model_step(input bit r, input int c, input bit clr, input bit ack);
    bit rise;
    bit done;
    rise = r && !m_rdy_prev;
    m_rdy_prev = r;
    done = 1'b0;
    if (clr) begin
      q.delete();
      m_overrun = 1'b0;
      m_range   = 1'b0;
    end else if (rise) begin
      if (c > DATA_SIZE) begin
        m_range = 1'b1;
      end else begin
        q.push_back(c);
        if (q.size() == BATCH) begin
          int s, mx, mn;
          s = 0; mx = 0; mn = DATA_SIZE;
          foreach (q[i]) begin
            s += q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
          end
          if (m_valid && !ack) m_overrun = 1'b1;
          m_valid = 1'b1;
          m_sum = s; m_max = mx; m_min = mn;
          q.delete();
          done = 1'b1;
        end
      end
    end
    if (!done && ack) m_valid = 1'b0;
  endtask

  // Compare every output of the DUT with the model.
  task automatic checkOutput(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".sum_out"},   32'(sum_out),   32'(m_sum));
    chk({tag, ".max_out"},   32'(max_out),   32'(m_max));
    chk({tag, ".min_out"},   32'(min_out),   32'(m_min));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_overrun));
    chk({tag, ".range_err"}, 32'(range_err), 32'(m_range));
  endtask

  // Drive one clock's worth of inputs on the falling edge, advance the model,
  // then check just after the rising edge.
  task automatic applyStimulus(input bit r, input int c, input bit clr, input bit ack,
                               input string tag);
    @(negedge clk);
    rdy     = r;
    cnt     = CNT_W'(c);
    clear   = clr;
    out_ack = ack;
    model_step(r, c, clr, ack);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // A two-cycle rdy pulse: low then high, with clear/ack applied on the rise.
  task automatic pulse(input int c, input bit clr, input bit ack, input string tag);
    applyStimulus(1'b0, c, 1'b0, 1'b0, tag);
    applyStimulus(1'b1, c, clr, ack, tag);
  endtask

  initial begin
    rst_b   = 1'b0;
    rdy     = 1'b1;
    cnt     = '0;
    clear   = 1'b0;
    out_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst_b = 1'b1;

    // rdy already high at reset release must not count
    $display("[TB] scenario: reset with rdy high, then 3,8,0,5");
    applyStimulus(1'b1, 3, 1'b0, 1'b0, "rdy_held_at_reset");
    pulse(3, 1'b0, 1'b0, "b1");
    pulse(8, 1'b0, 1'b0, "b1");
    pulse(0, 1'b0, 1'b0, "b1");
    pulse(5, 1'b0, 1'b0, "b1");
    chk("b1_valid_const", 32'(out_valid), 32'd1);
    chk("b1_sum_const",   32'(sum_out),   32'd16);
    chk("b1_max_const",   32'(max_out),   32'd8);
    chk("b1_min_const",   32'(min_out),   32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "b1_ack");
    chk("b1_ack_valid_const", 32'(out_valid), 32'd0);

    // rdy held high for ten cycles counts once
    $display("[TB] scenario: long rdy high");
    applyStimulus(1'b0, 2, 1'b0, 1'b0, "long");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2, 1'b0, 1'b0, "long");
    for (int i = 0; i < 3; i++) pulse(2, 1'b0, 1'b0, "long");
    chk("long_sum_const", 32'(sum_out), 32'd8);
    chk("long_max_const", 32'(max_out), 32'd2);
    chk("long_min_const", 32'(min_out), 32'd2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "long_ack");

    // Two batches without ack give an overrun
    $display("[TB] scenario: overrun");
    pulse(1, 1'b0, 1'b0, "ovr"); pulse(2, 1'b0, 1'b0, "ovr");
    pulse(3, 1'b0, 1'b0, "ovr"); pulse(4, 1'b0, 1'b0, "ovr");
    for (int i = 0; i < 4; i++) pulse(4, 1'b0, 1'b0, "ovr");
    chk("ovr_flag_const", 32'(overrun),   32'd1);
    chk("ovr_sum_const",  32'(sum_out),   32'd16);
    chk("ovr_valid_const", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "ovr_ack");
    chk("ovr_sticky_const", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, "ovr_clear");
    chk("ovr_cleared_const", 32'(overrun), 32'd0);

    // Completion in the same cycle as ack is not an overrun
    $display("[TB] scenario: completion with ack");
    for (int i = 0; i < 4; i++) pulse(6, 1'b0, 1'b0, "cack");
    pulse(1, 1'b0, 1'b0, "cack"); pulse(1, 1'b0, 1'b0, "cack");
    pulse(1, 1'b0, 1'b0, "cack"); pulse(2, 1'b0, 1'b1, "cack");
    chk("cack_valid_const",   32'(out_valid), 32'd1);
    chk("cack_overrun_const", 32'(overrun),   32'd0);
    chk("cack_sum_const",     32'(sum_out),   32'd5);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "cack_ack");

    // Out-of-range count is flagged and discarded
    $display("[TB] scenario: range error");
    pulse(9, 1'b0, 1'b0, "rng");
    for (int i = 0; i < 4; i++) pulse(1, 1'b0, 1'b0, "rng");
    chk("rng_flag_const", 32'(range_err), 32'd1);
    chk("rng_sum_const",  32'(sum_out),   32'd4);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, "rng_clear");
    chk("rng_cleared_const", 32'(range_err), 32'd0);

    // clear on a rdy rise drops the partial batch and that sample
    $display("[TB] scenario: clear mid-batch");
    pulse(1, 1'b0, 1'b0, "clr"); pulse(1, 1'b0, 1'b0, "clr");
    pulse(5, 1'b1, 1'b0, "clr");
    for (int i = 0; i < 4; i++) pulse(7, 1'b0, 1'b0, "clr");
    chk("clr_sum_const", 32'(sum_out), 32'd28);
    chk("clr_min_const", 32'(min_out), 32'd7);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "clr_ack");

    // Random run
    $display("[TB] scenario: random");
    for (int i = 0; i < 400; i++) begin
      bit r, clr, ack;
      int c;
      r   = ($urandom_range(0, 1) == 1);
      c   = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, DATA_SIZE);
      clr = ($urandom_range(0, 39) == 0);
      ack = ($urandom_range(0, 5) == 0);
      applyStimulus(r, c, clr, ack, "rand");
    end

    // Asynchronous reset mid-batch with a result pending
    $display("[TB] scenario: async reset");
    applyStimulus(1'b0, 0, 1'b1, 1'b1, "ar_prep");
    for (int i = 0; i < 4; i++) pulse(3, 1'b0, 1'b0, "ar");
    pulse(2, 1'b0, 1'b0, "ar"); pulse(2, 1'b0, 1'b0, "ar");
    chk("ar_valid_before_const", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    rdy = 1'b0;
    rst_b = 1'b1;
    m_rdy_prev = 1'b1;
    for (int i = 0; i < 4; i++) pulse(4, 1'b0, 1'b0, "post_reset");
    chk("post_reset_sum_const", 32'(sum_out), 32'd16);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
